// File: rtl/conv_lane_scheduler.sv
// Two-lane round-robin word scheduler feeding a byte-serial converter.
// Accepts one SIZE-bit word at a time and emits it MSB byte first, one byte per downstream handshake.
module conv_lane_scheduler #(
  parameter int SIZE = 16
) (
  input  logic            PCLK,
  input  logic            RESET,
  input  logic [SIZE-1:0] DATA_IN0,
  input  logic            VALID_IN0,
  output logic            READY0,
  input  logic [SIZE-1:0] DATA_IN1,
  input  logic            VALID_IN1,
  output logic            READY1,
  output logic [7:0]      DATA_OUT,
  output logic            VALID_OUT,
  output logic            SOF_OUT,
  output logic            LANE_OUT,
  input  logic            READY_OUT,
  output logic            o_dbg_state
);

  // Handshake: a word moves on an input lane when VALID_INx && READYx at a PCLK edge;
  // a byte moves downstream when VALID_OUT && READY_OUT at a PCLK edge.

  localparam int NB = SIZE / 8;
  localparam logic [1:0] LAST_IDX = 2'(NB - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          r_state;
  logic [SIZE-1:0] r_shift;
  logic [1:0]      r_cnt;
  logic            r_last_grant;
  logic [7:0]      r_data_out;
  logic            r_valid_out;
  logic            r_sof_out;
  logic            r_lane_out;

  logic            w_grant_valid;
  logic            w_grant_lane;
  logic [SIZE-1:0] w_word;

  // Grant is only offered in IDLE; with both lanes pending the lane not served last wins.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_lane  = 1'b0;
    if (r_state == IDLE && !RESET) begin
      if (VALID_IN0 && VALID_IN1) begin
        w_grant_valid = 1'b1;
        w_grant_lane  = ~r_last_grant;
      end else if (VALID_IN0) begin
        w_grant_valid = 1'b1;
        w_grant_lane  = 1'b0;
      end else if (VALID_IN1) begin
        w_grant_valid = 1'b1;
        w_grant_lane  = 1'b1;
      end
    end
  end

  assign READY0 = w_grant_valid & ~w_grant_lane;
  assign READY1 = w_grant_valid &  w_grant_lane;
  assign w_word = w_grant_lane ? DATA_IN1 : DATA_IN0;

  // DATA_OUT is loaded with the MSB byte on accept; r_shift then holds the remaining bytes left-aligned.
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_cnt        <= 2'd0;
      r_last_grant <= 1'b1;
      r_data_out   <= 8'h00;
      r_valid_out  <= 1'b0;
      r_sof_out    <= 1'b0;
      r_lane_out   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_state      <= SEND;
            r_shift      <= {w_word[SIZE-9:0], 8'h00};
            r_cnt        <= 2'd0;
            r_last_grant <= w_grant_lane;
            r_lane_out   <= w_grant_lane;
            r_data_out   <= w_word[SIZE-1 -: 8];
            r_valid_out  <= 1'b1;
            r_sof_out    <= 1'b1;
          end
        end
        SEND: begin
          if (READY_OUT) begin
            if (r_cnt == LAST_IDX) begin
              r_state     <= IDLE;
              r_valid_out <= 1'b0;
              r_sof_out   <= 1'b0;
            end else begin
              r_cnt      <= r_cnt + 2'd1;
              r_data_out <= r_shift[SIZE-1 -: 8];
              r_shift    <= {r_shift[SIZE-9:0], 8'h00};
              r_sof_out  <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign DATA_OUT    = r_data_out;
  assign VALID_OUT   = r_valid_out;
  assign SOF_OUT     = r_sof_out;
  assign LANE_OUT    = r_lane_out;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_conv_lane_scheduler.sv
// Bench for conv_lane_scheduler: one SIZE=16 and one SIZE=32 instance, each checked every cycle
// against a byte-queue model, plus literal checks on the directed scenarios.
module tb_conv_lane_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0]       v0;
  logic [1:0]       v1;
  logic [1:0]       rdy_out;
  logic [1:0][31:0] d0;
  logic [1:0][31:0] d1;
  wire  [1:0]       r0;
  wire  [1:0]       r1;
  wire  [1:0]       vo;
  wire  [1:0]       so;
  wire  [1:0]       lo;
  wire  [1:0][7:0]  dout;
  wire  [1:0]       dbg;

  int n_pass  = 0;
  int n_total = 0;
  logic armed = 1'b0;

  conv_lane_scheduler #(.SIZE(16)) dut16 (
    .PCLK(clk), .RESET(rst[0]),
    .DATA_IN0(d0[0][15:0]), .VALID_IN0(v0[0]), .READY0(r0[0]),
    .DATA_IN1(d1[0][15:0]), .VALID_IN1(v1[0]), .READY1(r1[0]),
    .DATA_OUT(dout[0]), .VALID_OUT(vo[0]), .SOF_OUT(so[0]), .LANE_OUT(lo[0]),
    .READY_OUT(rdy_out[0]), .o_dbg_state(dbg[0])
  );

  conv_lane_scheduler #(.SIZE(32)) dut32 (
    .PCLK(clk), .RESET(rst[1]),
    .DATA_IN0(d0[1]), .VALID_IN0(v0[1]), .READY0(r0[1]),
    .DATA_IN1(d1[1]), .VALID_IN1(v1[1]), .READY1(r1[1]),
    .DATA_OUT(dout[1]), .VALID_OUT(vo[1]), .SOF_OUT(so[1]), .LANE_OUT(lo[1]),
    .READY_OUT(rdy_out[1]), .o_dbg_state(dbg[1])
  );

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d t=%0t: got %h want %h", name, k, $time, act, exp);
  endtask

  // Model: per instance, a queue of bytes still to be delivered {lane, sof, byte}.
  logic [9:0] m_q [2][$];
  logic [7:0] m_hold_d [2];
  logic       m_hold_l [2];
  logic       m_last   [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_hold_d[k] = 8'h00;
      m_hold_l[k] = 1'b0;
      m_last[k]   = 1'b1;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin : per_inst
      int         nb;
      logic       busy, gv, gl;
      logic [31:0] w;
      logic [9:0] front;
      nb   = (k == 0) ? 2 : 4;
      busy = (m_q[k].size() != 0);
      front = busy ? m_q[k][0] : 10'h000;
      gv = 1'b0;
      gl = 1'b0;
      if (!busy && !rst[k]) begin
        if (v0[k] && v1[k]) begin gv = 1'b1; gl = ~m_last[k]; end
        else if (v0[k])     begin gv = 1'b1; gl = 1'b0; end
        else if (v1[k])     begin gv = 1'b1; gl = 1'b1; end
      end
      if (armed) begin
        chk("ready0", k, 32'(r0[k]), 32'(gv && !gl));
        chk("ready1", k, 32'(r1[k]), 32'(gv && gl));
        chk("valid_out", k, 32'(vo[k]), 32'(busy));
        chk("sof_out", k, 32'(so[k]), 32'(busy && front[8]));
        chk("data_out", k, 32'(dout[k]), busy ? 32'(front[7:0]) : 32'(m_hold_d[k]));
        chk("lane_out", k, 32'(lo[k]), busy ? 32'(front[9]) : 32'(m_hold_l[k]));
      end
      if (rst[k]) begin
        m_q[k].delete();
        m_hold_d[k] = 8'h00;
        m_hold_l[k] = 1'b0;
        m_last[k]   = 1'b1;
      end else if (busy) begin
        if (rdy_out[k]) begin
          m_hold_d[k] = front[7:0];
          m_hold_l[k] = front[9];
          void'(m_q[k].pop_front());
        end
      end else if (gv) begin
        w = gl ? d1[k] : d0[k];
        for (int i = 0; i < nb; i++)
          m_q[k].push_back({gl, (i == 0), w[8*(nb-1-i) +: 8]});
        m_last[k]   = gl;
        m_hold_l[k] = gl;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 2'b11; v0 = 2'b11; v1 = 2'b00; rdy_out = 2'b11;
    d0 = '0; d1 = '0;
    cyc();
    armed = 1'b1;
    #1;
    chk("rst_ready0", 0, 32'(r0[0]), 32'h0);
    chk("rst_dout", 1, 32'(dout[1]), 32'h0);
    chk("rst_valid", 0, 32'(vo[0]), 32'h0);
    cyc();
    rst = 2'b00; v0 = 2'b00;
    cyc();

    // Single word per instance: A5C3 on the 16-bit, DEADBEEF on the 32-bit, then reset mid-word.
    d0[0] = 32'h0000A5C3; d0[1] = 32'hDEADBEEF; v0 = 2'b11;
    #1;
    chk("acc_ready0", 0, 32'(r0[0]), 32'h1);
    chk("acc_ready0", 1, 32'(r0[1]), 32'h1);
    cyc();
    v0 = 2'b00;
    chk("b0", 0, {so[0], lo[0], dout[0]}, {1'b1, 1'b0, 8'hA5});
    chk("b0", 1, {so[1], dout[1]}, {1'b1, 8'hDE});
    cyc();
    chk("b1", 0, {so[0], dout[0]}, {1'b0, 8'hC3});
    chk("b1", 1, {so[1], dout[1]}, {1'b0, 8'hAD});
    rst[1] = 1'b1;
    cyc();
    rst[1] = 1'b0;
    chk("gap_valid", 0, 32'(vo[0]), 32'h0);
    chk("rst_mid", 1, {vo[1], so[1], lo[1], dout[1]}, 32'h0);
    d0[1] = 32'h11223344; d1[1] = 32'h55667788; v0[1] = 1'b1; v1[1] = 1'b1;
    #1;
    chk("post_rst_grant", 1, {r0[1], r1[1]}, 32'h2);
    cyc();
    v0 = 2'b00; v1 = 2'b00;
    repeat (6) cyc();

    // Both lanes continuously valid on the 16-bit instance, freshly reset.
    rst[0] = 1'b1;
    cyc();
    rst[0] = 1'b0;
    d0[0] = 32'h00001234; d1[0] = 32'h0000ABCD; v0[0] = 1'b1; v1[0] = 1'b1;
    cyc();
    chk("rr_b0", 0, 32'(dout[0]), 32'h12);
    cyc();
    chk("rr_b1", 0, 32'(dout[0]), 32'h34);
    cyc();
    chk("rr_gap_ready1", 0, {r0[0], r1[0]}, 32'h1);
    cyc();
    chk("rr_b2", 0, {lo[0], dout[0]}, {1'b1, 8'hAB});
    repeat (10) cyc();
    v0[0] = 1'b0; v1[0] = 1'b0;
    repeat (3) cyc();

    // Backpressure: lane 1 word 00FF with READY_OUT low for three cycles after the first byte.
    d1[0] = 32'h000000FF; v1[0] = 1'b1;
    cyc();
    v1[0] = 1'b0; rdy_out[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", 0, {vo[0], so[0], lo[0], dout[0]}, {1'b1, 1'b1, 1'b1, 8'h00});
      cyc();
    end
    rdy_out[0] = 1'b1;
    chk("bp_hold", 0, {vo[0], so[0], dout[0]}, {1'b1, 1'b1, 8'h00});
    cyc();
    chk("bp_next", 0, {vo[0], so[0], dout[0]}, {1'b1, 1'b0, 8'hFF});
    cyc();
    chk("bp_end", 0, {vo[0], dout[0]}, {1'b0, 8'hFF});

    // Lane 0 alone for three back-to-back words.
    d0[0] = 32'h00005A5A; v0[0] = 1'b1;
    repeat (9) cyc();
    v0[0] = 1'b0;
    repeat (3) cyc();

    // Random traffic, backpressure and occasional resets on both instances.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        v0[k]      = ($urandom_range(0, 3) != 0);
        v1[k]      = ($urandom_range(0, 2) == 0);
        rdy_out[k] = ($urandom_range(0, 3) != 0);
        rst[k]     = ($urandom_range(0, 199) == 0);
        d0[k]      = $urandom;
        d1[k]      = $urandom;
      end
      cyc();
    end
    rst = 2'b00; v0 = 2'b00; v1 = 2'b00; rdy_out = 2'b11;
    repeat (8) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
